instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
//
// PURPOSE
// Fetch stage directly upstream of processor_verilog. Reads 16-bit words from synchronous program memory
// (opcode at PC, operand at PC+1), assembles {opcode, operand, pc} instructions and buffers them in a small FIFO.
// Hands instructions to the processor over a valid/ready handshake; redirect input flushes the stage on jumps.
//
// PARAMETERS
// ADDR_W      16      program memory address width
// DATA_W      16      word width (opcode and operand each DATA_W)
// FIFO_DEPTH  2       instruction buffer entries; power of two, >=2
// RESET_PC    16'h0   fetch address after reset
//
// PORTS
// clk            in   1        single clock, all state on rising edge
// reset          in   1        asynchronous, active-low; asserted (0) clears all state immediately
// enable         in   1        1 = issue new instruction fetches
// mem_rd_en      out  1        program memory read strobe
// mem_addr       out  ADDR_W   program memory read address
// mem_rd_data    in   DATA_W   read data, valid exactly 1 cycle after mem_rd_en
// redirect_valid in   1        1-cycle pulse: flush and restart at redirect_pc
// redirect_pc    in   ADDR_W   new fetch address
// instr_valid    out  1        FIFO head holds an instruction
// instr_ready    in   1        processor accepts head this cycle
// opcode_out     out  DATA_W   head opcode
// operand_out    out  DATA_W   head operand
// instr_pc       out  ADDR_W   address of head opcode
// fetch_pc_out   out  ADDR_W   next opcode fetch address (debug)
//
// BEHAVIOUR
// - Reset (reset=0): mem_rd_en=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, instr_valid=0,
//   opcode_out/operand_out/instr_pc=0, state=IDLE, discard flag clear. Reset mid-operation drops all in-flight data.
// - States: IDLE -> ISSUE_OP -> ISSUE_ARG -> ISSUE_OP/IDLE.
//   IDLE: wait; go ISSUE_OP when enable=1 and free slot.
//   ISSUE_OP: mem_rd_en=1, mem_addr=fetch_pc; reserve one FIFO slot; -> ISSUE_ARG.
//   ISSUE_ARG: mem_rd_en=1, mem_addr=fetch_pc+1 (mod 2^ADDR_W); fetch_pc<=fetch_pc+2; -> ISSUE_OP if enable
//   and free slot, else IDLE. Operand read always follows an issued opcode read, regardless of enable.
// - Free slot: FIFO_DEPTH - count - reserved > 0 (reserved = instructions issued but not yet pushed, 0..1).
// - Return path: word returned the cycle after ISSUE_OP latched as opcode; word after ISSUE_ARG pushed into FIFO
//   with the latched opcode and its pc at end of that cycle. Peak throughput 1 instruction / 2 cycles.
// - Latency: enable=1 from reset release, opcode read cycle 0, operand read cycle 1, push end of cycle 2,
//   instr_valid=1 in cycle 3.
// - Handshake: pop when instr_valid & instr_ready. Head outputs stable while instr_valid=1 and not popped.
//   Push and pop in the same cycle allowed (count unchanged); push into full FIFO is impossible by reservation.
// - Empty: instr_valid=0, outputs hold last value; instr_ready ignored.
// - Redirect (priority over push, pop, issue): FIFO emptied, reservation cleared, latched opcode discarded,
//   any word returning next cycle ignored, fetch_pc<=redirect_pc, state<=IDLE; first read at redirect_pc
//   next cycle if enable=1. instr_valid=0 the cycle after redirect.
// - Wrap: fetch_pc arithmetic modulo 2^ADDR_W; opcode at 0xFFFF takes operand from 0x0000; instr_pc=0xFFFF.
// - Odd redirect_pc legal; no alignment rule.
//
// TESTING
// 1. Reset, mem[0..5]=1,2,3,4,5,6, enable=1, ready=1 -> reads at 0,1,2,3,...; instr (1,2,pc0) valid cycle 3,
//    then (3,4,pc2), (5,6,pc4) every 2 cycles.
// 2. ready=0, enable=1 -> exactly FIFO_DEPTH instructions buffered, mem_rd_en=0 thereafter, head held stable;
//    ready=1 -> drains in order, fetch resumes from pc 4.
// 3. Redirect to 0x0040 while operand read in flight and FIFO holds 1 entry -> instr_valid=0 next cycle,
//    in-flight word dropped, next read addr 0x0040, first valid instr pc=0x0040.
// 4. redirect_pc=0xFFFF, mem[0xFFFF]=A, mem[0]=B -> reads 0xFFFF then 0x0000; instr (A,B,pc 0xFFFF).
// 5. Pull reset low mid-fetch with FIFO full -> all outputs return to reset values without a clock edge;
//    release -> fetch restarts at RESET_PC.
// 6. enable dropped during ISSUE_OP -> operand still read, instruction delivered, then mem_rd_en stays 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads opcode/operand word pairs from synchronous program memory and
// queues {opcode, operand, pc} instructions for the processor over valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode_out,
  output logic [DATA_W-1:0] operand_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_W + ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE_OP, ISSUE_ARG} state_t;

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_n;
  logic                reserved_q, reserved_n;
  logic                rd_en_n;
  logic [ADDR_W-1:0]   addr_n;

  logic                ret_op_q, ret_arg_q;
  logic [DATA_W-1:0]   op_q;
  logic [ADDR_W-1:0]   pend_pc_q;

  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt_c;
  logic [CNT_W-1:0]    count_q, count_nxt_c;
  logic [CNT_W:0]      occ_c;
  logic [ENT_W-1:0]    push_data_c, head_nxt_c;
  logic                push_c, pop_c, slot_free_c;

  // Redirect overrides every push and pop in its cycle
  always_comb begin
    push_c      = ret_arg_q & ~redirect_valid;
    pop_c       = instr_valid & instr_ready & ~redirect_valid;
    push_data_c = {op_q, mem_rd_data, pend_pc_q};
    occ_c       = {1'b0, count_q} - (CNT_W+1)'(pop_c) + (CNT_W+1)'(reserved_q);
    slot_free_c = occ_c < (CNT_W+1)'(FIFO_DEPTH);
    rd_nxt_c    = rd_ptr_q + PTR_W'(pop_c);
    count_nxt_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    head_nxt_c  = (push_c && (wr_ptr_q == rd_nxt_c)) ? push_data_c : fifo_mem[rd_nxt_c];
  end

  // Issue FSM: next state, fetch pc, slot reservation and the registered memory strobe
  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    reserved_n = reserved_q;
    rd_en_n    = 1'b0;
    addr_n     = mem_addr;

    if (state_q == ISSUE_OP) reserved_n = 1'b1;
    else if (push_c)         reserved_n = 1'b0;

    case (state_q)
      IDLE:      if (enable && slot_free_c) state_n = ISSUE_OP;
      ISSUE_OP:  state_n = ISSUE_ARG;
      ISSUE_ARG: begin
        fetch_pc_n = fetch_pc_q + ADDR_W'(2);
        state_n    = (enable && slot_free_c) ? ISSUE_OP : IDLE;
      end
      default:   state_n = IDLE;
    endcase

    if (redirect_valid) begin
      state_n    = IDLE;
      fetch_pc_n = redirect_pc;
      reserved_n = 1'b0;
    end

    case (state_n)
      ISSUE_OP:  begin rd_en_n = 1'b1; addr_n = fetch_pc_n; end
      ISSUE_ARG: begin rd_en_n = 1'b1; addr_n = fetch_pc_n + ADDR_W'(1); end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      reserved_q <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      reserved_q <= reserved_n;
      mem_rd_en  <= rd_en_n;
      mem_addr   <= addr_n;
    end
  end

  assign fetch_pc_out = fetch_pc_q;

  // Return path: clearing the return flags on redirect drops any word still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_op_q  <= 1'b0;
      ret_arg_q <= 1'b0;
      op_q      <= '0;
      pend_pc_q <= '0;
    end else begin
      ret_op_q  <= (state_q == ISSUE_OP) & ~redirect_valid;
      ret_arg_q <= (state_q == ISSUE_ARG) & ~redirect_valid;
      if (ret_op_q && !redirect_valid) op_q <= mem_rd_data;
      if (state_q == ISSUE_OP) pend_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= push_data_c;
  end

  // Head outputs are registered copies of the next head; they hold when the FIFO drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_valid <= 1'b0;
      opcode_out  <= '0;
      operand_out <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q    <= rd_nxt_c;
      count_q     <= count_nxt_c;
      instr_valid <= (count_nxt_c != '0);
      if (count_nxt_c != '0) {opcode_out, operand_out, instr_pc} <= head_nxt_c;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected reads and instructions are
// queued by the directed tests and retired by independent negedge monitors.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] opcode_out, operand_out, instr_pc, fetch_pc_out;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_q [$];
  logic [47:0] ins_q [$];
  logic [15:0] exp_rd_v;
  logic [47:0] exp_ins_v;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .opcode_out     (opcode_out),
    .operand_out    (operand_out),
    .instr_pc       (instr_pc),
    .fetch_pc_out   (fetch_pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        total_cnt++;
        $display("FAIL rd_unexpected: got read at %h expected no read", mem_addr);
      end else begin
        exp_rd_v = rd_q.pop_front();
        chk("rd_addr", 64'(mem_addr), 64'(exp_rd_v));
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect_valid === 1'b0) begin
      if (ins_q.size() == 0) begin
        total_cnt++;
        $display("FAIL instr_unexpected: got op %h arg %h pc %h expected none",
                 opcode_out, operand_out, instr_pc);
      end else begin
        exp_ins_v = ins_q.pop_front();
        chk("instr", 64'({opcode_out, operand_out, instr_pc}), 64'(exp_ins_v));
      end
    end
  end

  task automatic exp_rd(input logic [15:0] a);
    rd_q.push_back(a);
  endtask

  task automatic exp_ins(input logic [15:0] op, input logic [15:0] arg, input logic [15:0] pc);
    ins_q.push_back({op, arg, pc});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},    64'(mem_rd_en),    64'd0);
    chk({tag, "_addr"},     64'(mem_addr),     64'd0);
    chk({tag, "_valid"},    64'(instr_valid),  64'd0);
    chk({tag, "_opcode"},   64'(opcode_out),   64'd0);
    chk({tag, "_operand"},  64'(operand_out),  64'd0);
    chk({tag, "_pc"},       64'(instr_pc),     64'd0);
    chk({tag, "_fetch_pc"}, 64'(fetch_pc_out), 64'd0);
  endtask

  // Leaves the bench just after the edge preceding cycle 0
  task automatic do_reset(input logic en, input logic rdy);
    reset = 1'b0;
    enable = en;
    instr_ready = rdy;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((rd_q.size() != 0 || ins_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(rd_q.size() + ins_q.size()), 64'd0);
    chk({tag, "_idle"},    64'(mem_rd_en), 64'd0);
  endtask

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 6; i++) mem[i] = 16'(i + 1);
    mem[16'h0040] = 16'hC0DE;
    mem[16'h0041] = 16'hBEEF;
    mem[16'h0042] = 16'hF00D;
    mem[16'h0043] = 16'hFACE;

    #1 reset = 1'b0;
    #2 check_reset_outputs("por");

    // 1: streaming fetch with latency check
    for (int a = 0; a < 6; a++) exp_rd(16'(a));
    exp_ins(16'd1, 16'd2, 16'h0000);
    exp_ins(16'd3, 16'd4, 16'h0002);
    exp_ins(16'd5, 16'd6, 16'h0004);
    do_reset(1'b1, 1'b1);
    cycle();
    chk("t1_first_rd_en", 64'(mem_rd_en), 64'd1);
    repeat (2) cycle();
    chk("t1_valid_c2", 64'(instr_valid), 64'd0);
    cycle();
    chk("t1_valid_c3", 64'(instr_valid), 64'd1);
    repeat (2) cycle();
    enable = 1'b0;
    drain("t1");

    // 2: backpressure fills exactly two entries, then drains and resumes at pc 4
    for (int a = 0; a < 6; a++) exp_rd(16'(a));
    exp_ins(16'd1, 16'd2, 16'h0000);
    exp_ins(16'd3, 16'd4, 16'h0002);
    exp_ins(16'd5, 16'd6, 16'h0004);
    do_reset(1'b1, 1'b0);
    repeat (8) cycle();
    for (int k = 0; k < 3; k++) begin
      chk("t2_stall_rd_en", 64'(mem_rd_en), 64'd0);
      chk("t2_head_held", 64'({instr_valid, opcode_out, operand_out, instr_pc}),
          64'({1'b1, 16'd1, 16'd2, 16'h0000}));
      cycle();
    end
    instr_ready = 1'b1;
    cycle();
    enable = 1'b0;
    drain("t2");
    chk("t2_fetch_pc", 64'(fetch_pc_out), 64'h0006);

    // 3: redirect while operand read in flight with one entry buffered
    exp_rd(16'h0000); exp_rd(16'h0001); exp_rd(16'h0002); exp_rd(16'h0003);
    exp_rd(16'h0040); exp_rd(16'h0041); exp_rd(16'h0042); exp_rd(16'h0043);
    exp_ins(16'hC0DE, 16'hBEEF, 16'h0040);
    exp_ins(16'hF00D, 16'hFACE, 16'h0042);
    do_reset(1'b1, 1'b0);
    repeat (4) cycle();
    chk("t3_pre_addr", 64'(mem_addr), 64'h0003);
    chk("t3_pre_valid", 64'(instr_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    cycle();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 64'(instr_valid), 64'd0);
    chk("t3_fetch_pc", 64'(fetch_pc_out), 64'h0040);
    repeat (8) cycle();
    chk("t3_full_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t3_head", 64'({instr_valid, opcode_out, operand_out, instr_pc}),
        64'({1'b1, 16'hC0DE, 16'hBEEF, 16'h0040}));
    enable = 1'b0;
    instr_ready = 1'b1;
    drain("t3");

    // 4: address wrap from 0xFFFF to 0x0000
    mem[16'hFFFF] = 16'hAAAA;
    mem[16'h0000] = 16'hBBBB;
    exp_rd(16'hFFFF); exp_rd(16'h0000);
    exp_ins(16'hAAAA, 16'hBBBB, 16'hFFFF);
    do_reset(1'b0, 1'b1);
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    cycle();
    redirect_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mem_rd_en === 1'b1) break;
    end
    enable = 1'b0;
    drain("t4");
    chk("t4_fetch_pc", 64'(fetch_pc_out), 64'h0001);

    // 6: enable dropped during the opcode read
    mem[16'h0000] = 16'h1111;
    mem[16'h0001] = 16'h2222;
    exp_rd(16'h0000); exp_rd(16'h0001);
    exp_ins(16'h1111, 16'h2222, 16'h0000);
    do_reset(1'b1, 1'b1);
    cycle();
    chk("t6_op_rd_en", 64'(mem_rd_en), 64'd1);
    enable = 1'b0;
    drain("t6");
    chk("t6_fetch_pc", 64'(fetch_pc_out), 64'h0002);

    // 5: asynchronous reset with a full buffer, then restart at RESET_PC
    for (int a = 0; a < 4; a++) exp_rd(16'(a));
    do_reset(1'b1, 1'b0);
    repeat (6) cycle();
    chk("t5_full_head", 64'({instr_valid, opcode_out, operand_out, instr_pc}),
        64'({1'b1, 16'h1111, 16'h2222, 16'h0000}));
    chk("t5_full_fetch_pc", 64'(fetch_pc_out), 64'h0004);
    @(negedge clk); #2;
    reset = 1'b0;
    #1 check_reset_outputs("t5_async");
    exp_rd(16'h0000); exp_rd(16'h0001);
    exp_ins(16'h1111, 16'h2222, 16'h0000);
    do_reset(1'b1, 1'b1);
    cycle();
    enable = 1'b0;
    drain("t5");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
